video_timing_gen: RTL and testbench

Generates raster timing for the DVI transmitter: a pixel-position counter pair plus hsync, vsync and data-enable, all from a parameterised video mode. It is the first stage of the video path. Its sync/DE outputs feed the pixel pipeline and the `delay` alignment stage. Its x/y outputs feed the pattern/pixel source, whose latency `delay` then matches.

---
 rtl/video_timing_gen.sv | 122 ++++++++++++
 tb/tb_video_timing_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel position counters plus hsync/vsync/de decode.
// Latency: one cycle; an enabled edge registers the decode of the position it consumes.
// Backpressure: en_i low freezes counters and every output, so no position is skipped or repeated.
//
// Ports:
//   clk_i    pixel clock
//   rst_ni   synchronous active-low reset (priority over en_i)
//   en_i     advance enable, one pixel per enabled clock
//   hsync_o  horizontal sync, active level H_POL
//   vsync_o  vertical sync, active level V_POL
//   de_o     data enable, high inside the active area
//   x_o/y_o  registered raster position
//   frame_o  one-update start-of-frame pulse at (0,0); only when
//            VIDEO_TIMING_FRAME_PULSE_EN is defined
//
// Region order per line and per frame: active, front porch, sync, back porch.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int W_X     = $clog2(H_TOTAL),
  localparam int W_Y     = $clog2(V_TOTAL)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           de_o,
  output logic [W_X-1:0] x_o,
`ifdef VIDEO_TIMING_FRAME_PULSE_EN
  output logic [W_Y-1:0] y_o,
  output logic           frame_o
`else
  output logic [W_Y-1:0] y_o
`endif
);

  // Region boundaries at counter width. The back porch is at least one
  // pixel/line, so the sync end is always a representable position.
  localparam logic [W_X-1:0] H_LAST      = W_X'(H_TOTAL - 1);
  localparam logic [W_X-1:0] H_ACT_END   = W_X'(H_ACTIVE);
  localparam logic [W_X-1:0] H_SYNC_BEG  = W_X'(H_ACTIVE + H_FRONT);
  localparam logic [W_X-1:0] H_SYNC_END  = W_X'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [W_Y-1:0] V_LAST      = W_Y'(V_TOTAL - 1);
  localparam logic [W_Y-1:0] V_ACT_END   = W_Y'(V_ACTIVE);
  localparam logic [W_Y-1:0] V_SYNC_BEG  = W_Y'(V_ACTIVE + V_FRONT);
  localparam logic [W_Y-1:0] V_SYNC_END  = W_Y'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  logic [W_X-1:0] h_cnt;
  logic [W_Y-1:0] v_cnt;
  logic [W_X-1:0] h_nxt;
  logic [W_Y-1:0] v_nxt;
  logic           h_wrap;
  logic           de_d;
  logic           hs_act;
  logic           vs_act;

  // Next position: horizontal wrap carries into the line counter, and the
  // line counter wraps only on the last pixel of the last line.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
  end

  // Decode of the position being consumed this cycle. vsync depends only on
  // the line, so its edges land on h = 0 at the output.
  always_comb begin
    de_d   = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs_act = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    vs_act = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      de_o    <= 1'b0;
      hsync_o <= !HS_ON;
      vsync_o <= !VS_ON;
      x_o     <= '0;
      y_o     <= '0;
    end else if (en_i) begin
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      de_o    <= de_d;
      hsync_o <= hs_act ? HS_ON : !HS_ON;
      vsync_o <= vs_act ? VS_ON : !VS_ON;
      x_o     <= h_cnt;
      y_o     <= v_cnt;
    end
  end

`ifdef VIDEO_TIMING_FRAME_PULSE_EN
  // Registered alongside the other outputs so it is high for exactly the one
  // update that presents (0,0), and holds while en_i is low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      frame_o <= 1'b0;
    end else if (en_i) begin
      frame_o <= (h_cnt == '0) && (v_cnt == '0);
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  localparam int HT = 8;
  localparam int VT = 6;
  localparam int FT = HT * VT;

  logic       clk_i;
  logic       rst_ni;
  logic       en_i;
  logic       hsync_o;
  logic       vsync_o;
  logic       de_o;
  logic [2:0] x_o;
  logic [2:0] y_o;
  logic       frame_o;

  video_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(0), .V_POL(0)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .hsync_o(hsync_o),
    .vsync_o(vsync_o),
    .de_o   (de_o),
    .x_o    (x_o),
`ifdef VIDEO_TIMING_FRAME_PULSE_EN
    .y_o    (y_o),
    .frame_o(frame_o)
`else
    .y_o    (y_o)
`endif
  );

`ifndef VIDEO_TIMING_FRAME_PULSE_EN
  assign frame_o = 1'b0;
`endif

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fr;
    logic [2:0] x;
    logic [2:0] y;
  } out_t;

  localparam out_t RST_OUT = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fr: 1'b0, x: 3'd0, y: 3'd0};

  int   n_checks = 0;
  int   n_pass   = 0;
  out_t exp_o;
  int   pos;        // linear raster index 0..FT-1 of the next position to be consumed

  // Reference: the position is a single linear index into the frame; x/y and
  // every flag come straight from the region table with plain arithmetic.
  function automatic out_t ref_decode(input int p);
    out_t o;
    int   x;
    int   y;
    x    = p % HT;
    y    = p / HT;
    o.x  = 3'(x);
    o.y  = 3'(y);
    o.de = (x < 4) && (y < 3);
    o.hs = !((x == 5) || (x == 6));
    o.vs = !(y == 4);
`ifdef VIDEO_TIMING_FRAME_PULSE_EN
    o.fr = (p == 0);
`else
    o.fr = 1'b0;
`endif
    return o;
  endfunction

  function automatic out_t observed();
    out_t o;
    o = '{hs: hsync_o, vs: vsync_o, de: de_o, fr: frame_o, x: x_o, y: y_o};
    return o;
  endfunction

  // Drive inputs on the falling edge, advance the model on the rising edge,
  // leave the caller sampling 1 time unit after the rising edge.
  task automatic tick(input logic en, input logic rst_n);
    @(negedge clk_i);
    en_i   = en;
    rst_ni = rst_n;
    @(posedge clk_i);
    if (!rst_n) begin
      exp_o = RST_OUT;
      pos   = 0;
    end else if (en) begin
      exp_o = ref_decode(pos);
      pos   = (pos + 1) % FT;
    end
    #1;
  endtask

  task automatic test_reset();
    out_t obs;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      obs = observed();
      n_checks++;
      if (obs !== RST_OUT) $display("FAIL reset_hold[%0d] got %h want %h", i, obs, RST_OUT);
      else n_pass++;
    end
  endtask

  task automatic test_first_line();
    out_t obs;
    for (int i = 0; i < HT; i++) begin
      tick(1'b1, 1'b1);
      obs = observed();
      n_checks++;
      if (obs !== exp_o || obs.x !== 3'(i) || obs.y !== 3'd0)
        $display("FAIL first_line[%0d] got %h want %h", i, obs, exp_o);
      else n_pass++;
    end
    tick(1'b1, 1'b1);
    n_checks++;
    if (y_o !== 3'd1 || x_o !== 3'd0) $display("FAIL line_step got x=%0d y=%0d want x=0 y=1", x_o, y_o);
    else n_pass++;
  endtask

  task automatic test_frame_wrap();
    out_t obs;
    int   vs_low;
    int   de_bad;
    int   cyc_err;
    vs_low  = 0;
    de_bad  = 0;
    cyc_err = 0;
    // 9 updates so far; finish the frame (48) and take one more to see the wrap.
    for (int i = 9; i < FT; i++) begin
      tick(1'b1, 1'b1);
      obs = observed();
      if (obs !== exp_o) cyc_err++;
      if (!vsync_o) begin
        vs_low++;
        if (y_o !== 3'd4) cyc_err++;
      end
      if (y_o >= 3'd3 && de_o) de_bad++;
    end
    n_checks++;
    if (cyc_err != 0) $display("FAIL frame_cycles got %0d mismatching updates want 0", cyc_err);
    else n_pass++;
    n_checks++;
    if (vs_low != 8) $display("FAIL vsync_width got %0d want 8", vs_low);
    else n_pass++;
    n_checks++;
    if (de_bad != 0) $display("FAIL de_blank got %0d want 0", de_bad);
    else n_pass++;
    tick(1'b1, 1'b1);
    n_checks++;
    if (x_o !== 3'd0 || y_o !== 3'd0 || de_o !== 1'b1)
      $display("FAIL frame_wrap got x=%0d y=%0d de=%b want x=0 y=0 de=1", x_o, y_o, de_o);
    else n_pass++;
  endtask

  task automatic test_enable_hold();
    logic en_pat[5];
    logic [2:0] x_want[5];
    out_t obs;
    en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    x_want = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2};
    tick(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(en_pat[i], 1'b1);
      obs = observed();
      n_checks++;
      if (obs !== exp_o || x_o !== x_want[i])
        $display("FAIL en_pattern[%0d] got %h x=%0d want %h x=%0d", i, obs, x_o, exp_o, x_want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    out_t obs;
    int   guard;
    guard = 0;
    while (!(x_o == 3'd5 && y_o == 3'd2) && guard < 200) begin
      tick(1'($urandom_range(0, 3) != 0), 1'b1);
      guard++;
    end
    n_checks++;
    if (guard >= 200) $display("FAIL reach_5_2 got x=%0d y=%0d want x=5 y=2", x_o, y_o);
    else n_pass++;
    tick(1'b1, 1'b0);
    obs = observed();
    n_checks++;
    if (obs !== RST_OUT) $display("FAIL mid_reset got %h want %h", obs, RST_OUT);
    else n_pass++;
    tick(1'b1, 1'b1);
    obs = observed();
    n_checks++;
    if (obs !== exp_o || x_o !== 3'd0 || y_o !== 3'd0 || de_o !== 1'b1)
      $display("FAIL restart got %h want %h", obs, exp_o);
    else n_pass++;
  endtask

  task automatic test_random();
    out_t obs;
    logic en;
    logic rn;
    for (int i = 0; i < 600; i++) begin
      en = 1'($urandom_range(0, 2) != 0);
      rn = 1'($urandom_range(0, 39) != 0);
      tick(en, rn);
      obs = observed();
      n_checks++;
      if (obs !== exp_o) $display("FAIL random[%0d] en=%b rst_n=%b got %h want %h", i, en, rn, obs, exp_o);
      else n_pass++;
    end
  endtask

`ifdef VIDEO_TIMING_FRAME_PULSE_EN
  task automatic test_frame_pulse();
    int hits[$];
    int bad;
    bad = 0;
    tick(1'b1, 1'b0);
    for (int u = 1; u <= 100; u++) begin
      tick(1'b1, 1'b1);
      if (frame_o) begin
        hits.push_back(u);
        if (x_o !== 3'd0 || y_o !== 3'd0) bad++;
      end
    end
    n_checks++;
    if (hits.size() != 3 || hits[0] != 1 || hits[1] != 49 || hits[2] != 97 || bad != 0)
      $display("FAIL frame_pulse got %0d pulses (bad pos %0d) want 3 at 1,49,97", hits.size(), bad);
    else n_pass++;
  endtask
`endif

  initial begin
    en_i   = 1'b0;
    rst_ni = 1'b0;
    exp_o  = RST_OUT;
    pos    = 0;
    test_reset();
    test_first_line();
    test_frame_wrap();
    test_enable_hold();
    test_reset_mid();
    test_random();
`ifdef VIDEO_TIMING_FRAME_PULSE_EN
    test_frame_pulse();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
